vrased_reset_seq: RTL and testbench
===================================

// Module: vrased_reset_seq
// PURPOSE
//  Downstream of the hardware access-control monitors (DMA key-region monitor and its siblings).
//  Collects their active-high violation/reset requests into the single core reset (PUC).
//  Stretches each reset to a guaranteed minimum width and re-asserts it while any request persists.
//  Latches which monitor caused the most recent reset for post-reset software inspection.
// PARAMETERS
//  NUM_SRC      4    number of monitor request inputs (1..8)
//  HOLD_CYCLES  16   minimum PUC assertion length in clk cycles (>=2)
//  CNT_W        5    width of hold counter; must satisfy 2**CNT_W > HOLD_CYCLES
// PORTS
//  clk        in   1        system clock; all logic on posedge
//  reset_n    in   1        synchronous, active-low reset
//  viol       in   NUM_SRC  per-monitor reset request, active-high, level (e.g. monitor 'reset' output)
//  cause_clr  in   1        single-cycle pulse; clears cause/ovf (honoured only in RUN)
//  puc_out    out  1        core reset, active-high, registered
//  cause      out  NUM_SRC  sticky snapshot of viol at the RUN->HOLD transition
//  cause_ovf  out  1        sticky: a further reset occurred while cause was nonzero
//  rst_cnt    out  8        saturating count of RUN->HOLD transitions
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): state=HOLD, hold_cnt=0, puc_out=1, cause=0, cause_ovf=0, rst_cnt=0.
//  States (2): RUN (puc_out=0), HOLD (puc_out=1). puc_out is a register equal to (next state==HOLD).
//  RUN:  |viol==1 at edge k -> HOLD after edge k (puc_out high in cycle k+1, 1-cycle latency);
//        hold_cnt<=0; rst_cnt<=rst_cnt+1 (saturate at 8'hFF, no wrap);
//        if cause==0: cause<=viol; else cause_ovf<=1 (cause unchanged).
//        |viol==0 -> stay RUN; if cause_clr: cause<=0, cause_ovf<=0.
//  HOLD: hold_cnt increments each cycle (saturating at HOLD_CYCLES-1).
//        hold_cnt==HOLD_CYCLES-1 and |viol==0 -> RUN (puc_out exactly HOLD_CYCLES cycles high).
//        hold_cnt==HOLD_CYCLES-1 and |viol==1 -> stay HOLD, hold_cnt<=0 (re-arm full window).
//        viol activity before final count is ignored (no counter restart, no cause/rst_cnt update).
//        cause_clr ignored in HOLD.
//  Simultaneous viol and cause_clr in RUN: violation wins; cause<=viol, cause_ovf<=0
//  (clear applied first, then load).
//  Entry into HOLD after reset_n does not count in rst_cnt and does not load cause.
//  reset_n low mid-HOLD: restart from reset values (counter back to 0, full window again).
//  viol is assumed synchronous to clk (monitors are same-clock registers); no synchroniser.
//  No combinational path from any input to any output.
// STRUCTURE
//  vrased_pkg: state encoding localparams (ST_RUN=1'b0, ST_HOLD=1'b1), RST_CNT_W=8.
//  One sub-module: vrased_sat_cnt #(W) (clr, inc, q) for rst_cnt; hold_cnt stays inline.
//  Top-level: state register, hold counter, cause/ovf registers, puc_out register.
// TESTING
//  1 reset_n low 3 cycles, viol=0 -> puc_out=1 for exactly 16 cycles after release, then 0; rst_cnt=0, cause=0.
//  2 RUN, viol=4'b0010 for 1 cycle -> puc_out=1 next cycle for 16 cycles; cause=4'b0010, rst_cnt=1.
//  3 RUN, viol=4'b0001 held 40 cycles -> puc_out high continuously until 16-cycle window ends after viol drops (48 total).
//  4 cause=4'b0010, second viol=4'b1000 -> cause stays 4'b0010, cause_ovf=1, rst_cnt=2; cause_clr in RUN -> both cleared.
//  5 RUN, cause_clr and viol=4'b0100 same edge -> HOLD, cause=4'b0100, cause_ovf=0.
//  6 300 violation events -> rst_cnt saturates at 8'hFF; reset_n mid-HOLD at count 10 -> fresh 16-cycle window.

Source files
------------

// File: rtl/vrased_reset_seq_pkg.sv
// Shared state encoding and widths for the reset sequencer.
package vrased_reset_seq_pkg;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   localparam int RST_CNT_W = 8;

endpackage

// File: rtl/vrased_reset_seq_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module vrased_reset_seq_sat_cnt #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;
   logic [W-1:0] w_q_d;

   always_comb begin
      w_q_d = r_q;
      if (i_clr) begin
         w_q_d = '0;
      end else if (i_inc && (r_q != {W{1'b1}})) begin
         w_q_d = r_q + W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_q <= '0;
      end else begin
         r_q <= w_q_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/vrased_reset_seq.sv
// Merges monitor reset requests into one stretched core reset (PUC) and records its cause.
module vrased_reset_seq
   import vrased_reset_seq_pkg::*;
#(
   parameter int NUM_SRC     = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int CNT_W       = 5
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic [NUM_SRC-1:0]   i_viol,
   input  logic                 i_cause_clr,
   output logic                 o_puc_out,
   output logic [NUM_SRC-1:0]   o_cause,
   output logic                 o_cause_ovf,
   output logic [RST_CNT_W-1:0] o_rst_cnt
);

   localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);

   state_e               r_state;
   state_e               w_state_d;
   logic [CNT_W-1:0]     r_hold_cnt;
   logic [CNT_W-1:0]     w_hold_cnt_d;
   logic [NUM_SRC-1:0]   r_cause;
   logic [NUM_SRC-1:0]   w_cause_d;
   logic                 r_ovf;
   logic                 w_ovf_d;
   logic                 r_puc;
   logic                 w_any;
   logic                 w_cnt_inc;
   logic [NUM_SRC-1:0]   w_cause_base;
   logic                 w_ovf_base;

   assign w_any = |i_viol;

   // A clear coinciding with a new violation is applied before the cause load.
   assign w_cause_base = i_cause_clr ? '0 : r_cause;
   assign w_ovf_base   = i_cause_clr ? 1'b0 : r_ovf;

   always_comb begin
      w_state_d    = r_state;
      w_hold_cnt_d = r_hold_cnt;
      w_cause_d    = r_cause;
      w_ovf_d      = r_ovf;
      w_cnt_inc    = 1'b0;
      unique case (r_state)
         ST_RUN: begin
            if (w_any) begin
               w_state_d    = ST_HOLD;
               w_hold_cnt_d = '0;
               w_cnt_inc    = 1'b1;
               if (w_cause_base == '0) begin
                  w_cause_d = i_viol;
                  w_ovf_d   = w_ovf_base;
               end else begin
                  w_cause_d = w_cause_base;
                  w_ovf_d   = 1'b1;
               end
            end else if (i_cause_clr) begin
               w_cause_d = '0;
               w_ovf_d   = 1'b0;
            end
         end
         ST_HOLD: begin
            if (r_hold_cnt >= HoldLast) begin
               // Requests still present at the window end re-arm a full window.
               if (w_any) begin
                  w_hold_cnt_d = '0;
               end else begin
                  w_state_d = ST_RUN;
               end
            end else begin
               w_hold_cnt_d = r_hold_cnt + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state    <= ST_HOLD;
         r_hold_cnt <= '0;
         r_cause    <= '0;
         r_ovf      <= 1'b0;
         r_puc      <= 1'b1;
      end else begin
         r_state    <= w_state_d;
         r_hold_cnt <= w_hold_cnt_d;
         r_cause    <= w_cause_d;
         r_ovf      <= w_ovf_d;
         r_puc      <= (w_state_d == ST_HOLD);
      end
   end

   vrased_reset_seq_sat_cnt #(
      .W (RST_CNT_W)
   ) u_rst_cnt (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clr     (1'b0),
      .i_inc     (w_cnt_inc),
      .o_q       (o_rst_cnt)
   );

   assign o_puc_out   = r_puc;
   assign o_cause     = r_cause;
   assign o_cause_ovf = r_ovf;

endmodule

// File: tb/tb_vrased_reset_seq.sv
// Randomised and directed stimulus for the reset sequencer, scored against a window-countdown model.
module tb_vrased_reset_seq;

   localparam int NUM_SRC = 4;
   localparam int HOLD    = 16;

   typedef struct packed {
      logic       puc;
      logic [3:0] cause;
      logic       ovf;
      logic [7:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] viol = '0;
   logic       cause_clr = 1'b0;
   logic       puc_out;
   logic [3:0] cause;
   logic       cause_ovf;
   logic [7:0] rst_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   exp_t exp_q[$];

   // Model: m_left = PUC cycles still owed (0 means running).
   int         m_left  = HOLD;
   logic [3:0] m_cause = '0;
   logic       m_ovf   = 1'b0;
   int         m_cnt   = 0;

   always #5 clk = ~clk;

   vrased_reset_seq #(
      .NUM_SRC     (NUM_SRC),
      .HOLD_CYCLES (HOLD),
      .CNT_W       (5)
   ) dut (
      .i_clk       (clk),
      .i_reset_n   (reset_n),
      .i_viol      (viol),
      .i_cause_clr (cause_clr),
      .o_puc_out   (puc_out),
      .o_cause     (cause),
      .o_cause_ovf (cause_ovf),
      .o_rst_cnt   (rst_cnt)
   );

   task automatic model_step(input logic rst, input logic [3:0] v, input logic clr);
      exp_t e;
      if (!rst) begin
         m_left  = HOLD;
         m_cause = '0;
         m_ovf   = 1'b0;
         m_cnt   = 0;
      end else if (m_left == 0) begin
         if (clr) begin
            m_cause = '0;
            m_ovf   = 1'b0;
         end
         if (v != 0) begin
            m_left = HOLD;
            if (m_cnt < 255) m_cnt = m_cnt + 1;
            if (m_cause == 0) m_cause = v;
            else m_ovf = 1'b1;
         end
      end else if (m_left == 1) begin
         m_left = (v != 0) ? HOLD : 0;
      end else begin
         m_left = m_left - 1;
      end
      e.puc   = (m_left != 0);
      e.cause = m_cause;
      e.ovf   = m_ovf;
      e.cnt   = 8'(m_cnt);
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic rst, input logic [3:0] v, input logic clr);
      @(negedge clk);
      reset_n   = rst;
      viol      = v;
      cause_clr = clr;
      model_step(rst, v, clr);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 4'b0000, 1'b0);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every cycle the DUT presents a new output word.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("puc_out", 32'(puc_out), 32'(e.puc));
            check("cause", 32'(cause), 32'(e.cause));
            check("cause_ovf", 32'(cause_ovf), 32'(e.ovf));
            check("rst_cnt", 32'(rst_cnt), 32'(e.cnt));
         end
      end
   end

   initial begin
      // Reset, then the power-up window.
      repeat (3) drive(1'b0, 4'b0000, 1'b0);
      idle(20);
      // Single-cycle request.
      drive(1'b1, 4'b0010, 1'b0);
      idle(20);
      // Clear, then a long-held request.
      drive(1'b1, 4'b0000, 1'b1);
      for (int i = 0; i < 40; i++) drive(1'b1, 4'b0001, 1'b0);
      idle(20);
      // Overflow: second cause while the first is still recorded.
      drive(1'b1, 4'b0000, 1'b1);
      drive(1'b1, 4'b0010, 1'b0);
      idle(18);
      drive(1'b1, 4'b1000, 1'b0);
      idle(18);
      // Request during HOLD before the final count is ignored.
      drive(1'b1, 4'b0100, 1'b0);
      idle(5);
      drive(1'b1, 4'b1111, 1'b0);
      idle(15);
      drive(1'b1, 4'b0000, 1'b1);
      idle(2);
      // Clear and request on the same edge.
      drive(1'b1, 4'b0001, 1'b0);
      idle(18);
      drive(1'b1, 4'b0100, 1'b1);
      idle(18);
      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         logic [3:0] v;
         v = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
         drive(($urandom_range(0, 200) != 0), v, ($urandom_range(0, 6) == 0));
      end
      idle(20);
      // Saturate the reset counter.
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 4'($urandom_range(1, 15)), 1'b0);
         idle(16);
      end
      // Reset mid-HOLD restarts a full window.
      drive(1'b1, 4'b0010, 1'b0);
      idle(10);
      drive(1'b0, 4'b0000, 1'b0);
      idle(20);
      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
